// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_mem_ctrl_if : request/response bus between the CPU and data_mem_ctrl
// Revision 1.0
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_mem_ctrl : byte/half/word data memory with handshake, wait states and
//                 an independent debug read port
// Revision 1.0
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 7,
  parameter int WAIT_CYCLES = 0,
  parameter int INIT_MODE   = 1
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_ctrl_if.slave    bus,
  input  logic [ADDR_W-3:0] dbg_addr_i,
  output logic [31:0]       dbg_rdata_o
);

  if (ADDR_W != $clog2(DEPTH) + 2) begin : g_bad_addr_w
    $error("data_mem_ctrl: ADDR_W must equal log2(DEPTH)+2");
  end

  typedef logic [31:0] mem_t [DEPTH];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (INIT_MODE == 1) ? 32'(i + 1) : 32'd0;
    end
    return m;
  endfunction

  // Contents survive reset; only the power-up image is defined.
  mem_t mem_q = init_mem();

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              ready_q;
  logic              rvalid_q;
  logic              rerr_q;
  logic [31:0]       rdata_q;
  logic [31:0]       dbg_q;

  logic              w_req_err;
  logic [ADDR_W-3:0] w_widx;
  logic [31:0]       w_old;
  logic [31:0]       w_shift;
  logic [3:0]        w_be;
  logic [31:0]       w_wlane;
  logic [31:0]       w_load;
  logic              w_commit;
  logic              w_mem_we;

  always_comb begin
    w_req_err = 1'b0;
    case (bus.req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = bus.req_addr[0];
      2'b10:   w_req_err = |bus.req_addr[1:0];
      default: w_req_err = 1'b1;
    endcase
  end

  assign w_widx  = addr_q[ADDR_W-1:2];
  assign w_old   = mem_q[w_widx];
  assign w_shift = w_old >> {addr_q[1:0], 3'b000};

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'b1111;
    w_wlane = wdata_q;
    w_load  = w_old;
    case (size_q)
      2'b00: begin
        w_be    = 4'b0001 << addr_q[1:0];
        w_wlane = {4{wdata_q[7:0]}};
        w_load  = {{24{~uns_q & w_shift[7]}}, w_shift[7:0]};
      end
      2'b01: begin
        w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{wdata_q[15:0]}};
        w_load  = {{16{~uns_q & w_shift[15]}}, w_shift[15:0]};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = wdata_q;
        w_load  = w_old;
      end
    endcase
  end

  assign w_commit = (state_q == S_BUSY) && (cnt_q == 4'd0);
  assign w_mem_we = w_commit & we_q;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_widx][8*b +: 8] <= w_wlane[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && ready_q) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            ready_q <= 1'b0;
            if (w_req_err) begin
              state_q  <= S_ERR;
              rvalid_q <= 1'b1;
              rerr_q   <= 1'b1;
              rdata_q  <= 32'd0;
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q  <= S_RESP;
            rvalid_q <= 1'b1;
            rerr_q   <= 1'b0;
            rdata_q  <= we_q ? 32'd0 : w_load;
          end
        end
        S_RESP, S_ERR: begin
          state_q  <= S_IDLE;
          rvalid_q <= 1'b0;
          rerr_q   <= 1'b0;
          rdata_q  <= 32'd0;
          ready_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reads the array before any same-edge commit lands, so a colliding store shows next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_q <= 32'd0;
    end else begin
      dbg_q <= mem_q[dbg_addr_i];
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_err   = rerr_q;
  assign bus.resp_rdata = rdata_q;
  assign dbg_rdata_o    = dbg_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl : two instances (0 and 3 wait states) against a memory model
// Revision 1.0
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 7;
  localparam int DW     = ADDR_W - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus0 ();
  data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus1 ();

  logic              t_valid [2];
  logic              t_we    [2];
  logic              t_uns   [2];
  logic [1:0]        t_size  [2];
  logic [ADDR_W-1:0] t_addr  [2];
  logic [31:0]       t_wdata [2];
  logic [DW-1:0]     t_dbg   [2];
  logic              o_ready [2];
  logic              o_valid [2];
  logic              o_err   [2];
  logic [31:0]       o_rdata [2];
  logic [31:0]       o_dbg   [2];
  logic [31:0]       o_dbg0, o_dbg1;

  assign bus0.req_valid = t_valid[0];  assign bus1.req_valid = t_valid[1];
  assign bus0.req_we = t_we[0];        assign bus1.req_we = t_we[1];
  assign bus0.req_size = t_size[0];    assign bus1.req_size = t_size[1];
  assign bus0.req_unsigned = t_uns[0]; assign bus1.req_unsigned = t_uns[1];
  assign bus0.req_addr = t_addr[0];    assign bus1.req_addr = t_addr[1];
  assign bus0.req_wdata = t_wdata[0];  assign bus1.req_wdata = t_wdata[1];
  assign o_ready[0] = bus0.req_ready;  assign o_ready[1] = bus1.req_ready;
  assign o_valid[0] = bus0.resp_valid; assign o_valid[1] = bus1.resp_valid;
  assign o_err[0] = bus0.resp_err;     assign o_err[1] = bus1.resp_err;
  assign o_rdata[0] = bus0.resp_rdata; assign o_rdata[1] = bus1.resp_rdata;
  assign o_dbg[0] = o_dbg0;            assign o_dbg[1] = o_dbg1;

  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(0), .INIT_MODE(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_addr_i(t_dbg[0]), .dbg_rdata_o(o_dbg0)
  );
  data_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(3), .INIT_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_addr_i(t_dbg[1]), .dbg_rdata_o(o_dbg1)
  );

  // Model state: memory image, expected response window and pending store.
  logic [31:0] mmem [2][DEPTH];
  int          waitc [2] = '{0, 3};
  int          cyc = 0;
  int          acc_e [2] = '{-100, -100};
  int          resp_e [2] = '{-100, -100};
  bit          pend_v [2];
  int          pend_e [2];
  int          pend_i [2];
  logic [31:0] pend_w [2];
  logic        exp_err [2];
  logic [31:0] exp_rd [2];
  logic [31:0] exp_dbg [2];
  bit          dbg_lock [2];
  int          compared = 0;
  int          mismatched = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_access(input logic [31:0] word, input logic [1:0] size,
                                       input logic uns, input int addr, input logic [31:0] wdata,
                                       output logic err, output logic [31:0] load,
                                       output logic [31:0] stored);
    int off;
    int nb;
    logic [31:0] mask;
    off = addr % 4;
    err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && off != 0);
    load = 32'd0;
    stored = word;
    if (!err) begin
      nb   = 1 << size;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      load = (word >> (8 * off)) & mask;
      if (!uns && nb < 4 && load[8*nb-1]) load = load | ~mask;
      stored = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
    end
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int id = 0; id < 2; id++) begin
      exp_dbg[id] = rst ? 32'd0 : mmem[id][t_dbg[id]];
      if (!rst && pend_v[id] && pend_e[id] == cyc) begin
        mmem[id][pend_i[id]] = pend_w[id];
        pend_v[id] = 1'b0;
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        logic ev;
        ev = (cyc == resp_e[id]);
        check($sformatf("ready%0d", id), 32'(o_ready[id]),
              32'(!(cyc >= acc_e[id] && cyc <= resp_e[id])));
        check($sformatf("resp_valid%0d", id), 32'(o_valid[id]), 32'(ev));
        if (ev) begin
          check($sformatf("resp_err%0d", id), 32'(o_err[id]), 32'(exp_err[id]));
          check($sformatf("resp_rdata%0d", id), o_rdata[id], exp_rd[id]);
        end
        check($sformatf("dbg_rdata%0d", id), o_dbg[id], exp_dbg[id]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_req(input int id, input logic we, input logic [1:0] size, input logic uns,
                        input int addr, input logic [31:0] wdata,
                        output logic [31:0] mload, output logic merr);
    logic [31:0] st;
    int widx;
    widx = addr / 4;
    model_access(mmem[id][widx], size, uns, addr, wdata, merr, mload, st);
    acc_e[id]   = cyc + 1;
    resp_e[id]  = merr ? acc_e[id] : acc_e[id] + waitc[id] + 1;
    exp_err[id] = merr;
    exp_rd[id]  = (merr || we) ? 32'd0 : mload;
    if (!merr && we) begin
      pend_v[id] = 1'b1;
      pend_e[id] = resp_e[id];
      pend_i[id] = widx;
      pend_w[id] = st;
    end
    t_we[id] = we; t_size[id] = size; t_uns[id] = uns;
    t_addr[id] = ADDR_W'(addr); t_wdata[id] = wdata; t_valid[id] = 1'b1;
    if (!dbg_lock[id]) t_dbg[id] = DW'($urandom_range(0, DEPTH - 1));
    step();
    // Junk requests while busy must be ignored; fields need not be held.
    while (cyc <= resp_e[id]) begin
      t_valid[id] = 1'($urandom_range(0, 1));
      t_we[id]    = 1'($urandom_range(0, 1));
      t_size[id]  = 2'($urandom_range(0, 3));
      t_uns[id]   = 1'($urandom_range(0, 1));
      t_addr[id]  = ADDR_W'($urandom_range(0, 127));
      t_wdata[id] = $urandom;
      if (!dbg_lock[id]) t_dbg[id] = DW'($urandom_range(0, DEPTH - 1));
      step();
    end
    t_valid[id] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int id = 0; id < 2; id++) begin
      pend_v[id] = 1'b0;
      acc_e[id] = -100;
      resp_e[id] = -100;
      exp_dbg[id] = 32'd0;
      t_valid[id] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic        e;
    for (int id = 0; id < 2; id++) begin
      t_valid[id] = 1'b0; t_we[id] = 1'b0; t_uns[id] = 1'b0; t_size[id] = 2'b00;
      t_addr[id] = '0; t_wdata[id] = 32'd0; t_dbg[id] = '0;
      exp_dbg[id] = 32'd0; exp_err[id] = 1'b0; exp_rd[id] = 32'd0;
      pend_v[id] = 1'b0; dbg_lock[id] = 1'b0;
      for (int i = 0; i < DEPTH; i++) mmem[id][i] = 32'(i + 1);
    end
    step();
    step();
    rst = 1'b0;
    step();

    do_req(0, 1'b0, 2'd2, 1'b0, 'h08, 32'd0, v, e);
    check("lw_08", v, 32'h0000_0003);
    check("lw_08_err", 32'(e), 32'd0);
    do_req(0, 1'b1, 2'd0, 1'b0, 'h05, 32'h1234_56AB, v, e);
    check("sb_05_word1", mmem[0][1], 32'h0000_AB02);
    do_req(0, 1'b0, 2'd0, 1'b0, 'h05, 32'd0, v, e);
    check("lb_05", v, 32'hFFFF_FFAB);
    do_req(0, 1'b0, 2'd0, 1'b1, 'h05, 32'd0, v, e);
    check("lbu_05", v, 32'h0000_00AB);
    do_req(0, 1'b0, 2'd1, 1'b0, 'h04, 32'd0, v, e);
    check("lh_04", v, 32'hFFFF_AB02);
    do_req(0, 1'b0, 2'd2, 1'b0, 'h0A, 32'd0, v, e);
    check("lw_0A_err", 32'(e), 32'd1);
    do_req(0, 1'b1, 2'd1, 1'b0, 'h03, 32'h0000_FFFF, v, e);
    check("sh_03_err", 32'(e), 32'd1);
    check("word2_kept", mmem[0][2], 32'h0000_0003);
    check("word0_kept", mmem[0][0], 32'h0000_0001);
    do_req(0, 1'b0, 2'd3, 1'b0, 'h00, 32'd0, v, e);
    check("size11_err", 32'(e), 32'd1);

    dbg_lock[0] = 1'b1;
    t_dbg[0] = DW'(31);
    step();
    check("dbg_31", exp_dbg[0], 32'h0000_0020);
    t_dbg[0] = DW'(4);
    step();
    do_req(0, 1'b1, 2'd2, 1'b0, 'h10, 32'hCAFE_F00D, v, e);
    check("dbg_4_after_commit", exp_dbg[0], 32'hCAFE_F00D);
    dbg_lock[0] = 1'b0;

    do_req(1, 1'b0, 2'd2, 1'b0, 'h08, 32'd0, v, e);
    check("w3_lw_08", v, 32'h0000_0003);

    // Word store aborted by reset while still counting down.
    t_we[1] = 1'b1; t_size[1] = 2'd2; t_uns[1] = 1'b0;
    t_addr[1] = ADDR_W'('h10); t_wdata[1] = 32'hDEAD_BEEF; t_valid[1] = 1'b1;
    acc_e[1] = cyc + 1; resp_e[1] = acc_e[1] + 4;
    exp_err[1] = 1'b0; exp_rd[1] = 32'd0;
    pend_v[1] = 1'b1; pend_e[1] = resp_e[1]; pend_i[1] = 4; pend_w[1] = 32'hDEAD_BEEF;
    step();
    t_valid[1] = 1'b0;
    step();
    do_reset();
    step();
    check("rst_word4_model", mmem[1][4], 32'h0000_0005);
    do_req(1, 1'b0, 2'd2, 1'b0, 'h10, 32'd0, v, e);
    check("rst_word4_load", v, 32'h0000_0005);

    for (int id = 0; id < 2; id++) begin
      for (int n = 0; n < 150; n++) begin
        logic [1:0] sz;
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        do_req(id, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 127)), $urandom, v, e);
      end
    end
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised data memory for the multi-cycle CPU, with a request/response handshake.
- Handles load/store size (byte/half/word) with sign or zero extension and generates byte-lane enables internally.
- Detects misaligned and unsupported accesses and inserts a configurable number of wait states.
- Provides an independent synchronous debug read port for on-board display.

Parameters:
- DEPTH, 32, number of 32-bit words; must be a power of two ≥ 2.
- ADDR_W, 7, byte address width; must equal log2(DEPTH)+2.
- WAIT_CYCLES, 0, extra wait states between accepting a request and committing the access (0..15).
- INIT_MODE, 1, power-up contents: 1 gives word i = i+1; 0 gives all zero.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  access rejected; qualified by resp_valid.
- dbg_addr  in  ADDR_W-2  debug word address.
- dbg_rdata  out  32  debug read data.

Behaviour:
- Reset is asynchronous and active-high on rst; single clock clk.
- Reset values: FSM = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, dbg_rdata = 0, wait counter = 0.
- Memory array is not cleared by reset; it is initialised only at time zero according to INIT_MODE.
- FSM states:
  - IDLE: req_ready = 1. Accept on req_valid & req_ready and latch all req_* fields.
    - Go to ERR if req_size = 11, or half with addr[0] ≠ 0, or word with addr[1:0] ≠ 0.
    - Otherwise load counter = WAIT_CYCLES and go to BUSY.
  - BUSY: req_ready = 0. If counter ≠ 0, decrement. If counter = 0, commit the access at this edge, register the load result, and go to RESP.
  - RESP: resp_valid = 1, resp_err = 0 for one cycle; return to IDLE.
  - ERR: resp_valid = 1, resp_err = 1, resp_rdata = 0 for one cycle; no memory write; return to IDLE.
- Latency, with the accept edge as cycle 0:
  - Legal access: resp_valid is high during cycle WAIT_CYCLES+2.
  - Error: resp_valid is high during cycle 1.
  - req_ready is low from the accept edge until the cycle after resp_valid.
  - No back-to-back accept while resp_valid is high.
- req_valid is ignored when req_ready = 0. The requester is not required to hold fields after acceptance.
- Store lanes (little-endian, word index = addr[ADDR_W-1:2]):
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes {1,0} or {3,2} selected by addr[1] get wdata[15:0].
  - Word: all four lanes.
  - Unselected lanes retain their old value.
- Load: select the same lane(s), then extend to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- Debug port: reads word dbg_addr every cycle with one-cycle latency and no gating; it is independent of the FSM.
  - If a store commits to the same word at the same edge, dbg_rdata shows the pre-write value; the new value appears on the next read.
- Reset mid-operation: FSM returns to IDLE immediately. An uncommitted store is dropped and memory is unchanged. No response is issued for the aborted request.

Test Plan:
- INIT_MODE = 1, WAIT_CYCLES = 0, load word at addr 0x08 -> resp_valid at cycle 2, resp_rdata = 0x00000003, resp_err = 0.
- Store byte at 0x05 with wdata 0x123456AB -> word 1 = 0x0000AB02.
  - Then signed byte load at 0x05 -> 0xFFFFFFAB.
  - Unsigned byte load at 0x05 -> 0x000000AB.
  - Signed half load at 0x04 -> 0xFFFFAB02.
- Misaligned word load at 0x0A and half store at 0x03 -> resp_err = 1 at cycle 1, resp_rdata = 0, memory words 2 and 0 unchanged.
- Illegal access with req_size = 11 -> same error response.
- WAIT_CYCLES = 3: accept at cycle 0 -> req_ready low in cycles 1–5, resp_valid only in cycle 5.
  - A req_valid asserted during cycles 1–4 is not accepted.
- Assert rst during BUSY of a word store of 0xDEADBEEF to 0x10 -> outputs return to reset values, word 4 stays 0x00000005, and no resp_valid is issued.
- dbg_addr = 31 -> dbg_rdata = 0x00000020 next cycle.
  - Debug read of word 4 coincident with a commit of 0xCAFEF00D to word 4 -> old value first, 0xCAFEF00D on the following cycle.
